// File: rtl/instr_issuer_if.sv
// Instruction/result link between the issuer (master) and the compute unit (slave).
// en qualifies instruction for one cycle; there is no ready, so the compute unit takes every
// en-high beat. data_valid qualifies data/reg_id in the same way on the return path.
interface instr_issuer_if;
  logic [15:0] instruction;
  logic        en;
  logic [7:0]  data;
  logic        data_valid;
  logic [3:0]  reg_id;

  modport master (output instruction, en, input data, data_valid, reg_id);
  modport slave  (input instruction, en, output data, data_valid, reg_id);
endinterface

// File: rtl/instr_issuer.sv
// Buffers a byte-loaded program of 16-bit instructions and issues it back-to-back to the compute unit.
// Optional macro INSTR_OPCODE_CHECK_EN: opcodes 8-15 are issued as No-Op and flag the sticky err.
module instr_issuer #(
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = 3,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        byte_in,
  input  logic              byte_wr,
  input  logic              clr,
  input  logic              start,
  instr_issuer_if.master    cu,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [7:0]        result,
  output logic [3:0]        result_reg,
  output logic [ADDR_W:0]   result_cnt,
  output logic              ovf,
  output logic              err,
  output logic [1:0]        state_dbg
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t          state;
  logic [15:0]     slots [DEPTH];
  logic [7:0]      hi_byte;
  logic            half;
  logic [CW-1:0]   pc;
  logic [7:0]      drain_cnt;
  logic [15:0]     cur_instr;
  logic [CW-1:0]   pc_next;
  logic            wr_slot;

  assign state_dbg = state;
  assign busy      = (state == S_ISSUE) || (state == S_DRAIN);
  assign cur_instr = slots[pc[ADDR_W-1:0]];
  assign pc_next   = pc + ONE;
  // Second byte of a pair completes an instruction; clr and start both pre-empt a write.
  assign wr_slot   = (state == S_IDLE) && !clr && !start && byte_wr && half && (count != FULL);

  always_ff @(posedge clk) begin
    if (wr_slot) slots[count[ADDR_W-1:0]] <= {hi_byte, byte_in};
  end

`ifdef INSTR_OPCODE_CHECK_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      cu.instruction <= '0;
      cu.en          <= 1'b0;
      done           <= 1'b0;
      count          <= '0;
      result         <= '0;
      result_reg     <= '0;
      result_cnt     <= '0;
      ovf            <= 1'b0;
      hi_byte        <= '0;
      half           <= 1'b0;
      pc             <= '0;
      drain_cnt      <= '0;
`ifdef INSTR_OPCODE_CHECK_EN
      err_q          <= 1'b0;
`endif
    end else begin
      done           <= 1'b0;
      cu.en          <= 1'b0;
      cu.instruction <= '0;

      if (cu.data_valid) begin
        result     <= cu.data;
        result_reg <= cu.reg_id;
        if (result_cnt != FULL) result_cnt <= result_cnt + ONE;
      end

      case (state)
        S_IDLE: begin
          if (clr) begin
            count <= '0;
            half  <= 1'b0;
            ovf   <= 1'b0;
`ifdef INSTR_OPCODE_CHECK_EN
            err_q <= 1'b0;
`endif
          end else if (start) begin
            // Any orphan high byte is dropped by clearing half.
            result_cnt <= '0;
            pc         <= '0;
            half       <= 1'b0;
            state      <= (count == '0) ? S_DONE : S_ISSUE;
          end else if (byte_wr) begin
            if (count == FULL) begin
              ovf <= 1'b1;
            end else if (!half) begin
              hi_byte <= byte_in;
              half    <= 1'b1;
            end else begin
              count <= count + ONE;
              half  <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          cu.en <= 1'b1;
`ifdef INSTR_OPCODE_CHECK_EN
          if (cur_instr[15]) begin
            cu.instruction <= '0;
            err_q          <= 1'b1;
          end else begin
            cu.instruction <= cur_instr;
          end
`else
          cu.instruction <= cur_instr;
`endif
          pc <= pc_next;
          if (pc_next == count) begin
            state     <= S_DRAIN;
            drain_cnt <= 8'(DRAIN_CYCLES);
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt - 8'd1;
          if (drain_cnt <= 8'd1) state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
